// File: rtl/dffram_burst_writer.sv
// dffram_burst_writer: splits a byte stream into low/high nibble writes on a DFFRAM port.
module dffram_burst_writer #(
  parameter int AWIDTH   = 4,
  parameter int CNTWIDTH = AWIDTH + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AWIDTH-1:0]   start_addr,
  input  logic                s_valid,
  input  logic [7:0]          s_data,
  input  logic                s_last,
  output logic                s_ready,
  output logic [AWIDTH-1:0]   ram_addr,
  output logic [3:0]          ram_wdata,
  output logic                ram_lohi,
  output logic                ram_w_en,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic [CNTWIDTH-1:0] count
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ACCEPT = 3'd1;
  localparam logic [2:0] WR_LO  = 3'd2;
  localparam logic [2:0] WR_HI  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  logic [2:0] state;
  logic [7:0] byte_q;
  logic       last_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      byte_q   <= '0;
      last_q   <= 1'b0;
      ram_addr <= '0;
      count    <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ram_addr <= start_addr;
          count    <= '0;
          ovf      <= 1'b0;
          state    <= ACCEPT;
        end
        ACCEPT: if (s_valid) begin
          byte_q <= s_data;
          last_q <= s_last;
          state  <= WR_LO;
        end
        WR_LO: state <= WR_HI;
        WR_HI: begin
          count <= count + CNTWIDTH'(count != '1);
          // running off the top address without s_last is an overflow
          if (last_q || ram_addr == '1) begin
            ovf   <= ~last_q;
            state <= DONE;
          end else begin
            ram_addr <= ram_addr + AWIDTH'(1);
            state    <= ACCEPT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign s_ready   = state == ACCEPT;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign ram_w_en  = state == WR_LO || state == WR_HI;
  assign ram_lohi  = state == WR_LO;
  assign ram_wdata = state == WR_LO ? byte_q[3:0] : state == WR_HI ? byte_q[7:4] : 4'h0;
endmodule

// File: tb/tb_dffram_burst_writer.sv
// tb_dffram_burst_writer: cycle-exact directed vectors plus reset/start corner sequences.
module tb_dffram_burst_writer;
  typedef struct packed {
    logic       rdy, wen, lohi;
    logic [3:0] wd, ad;
    logic       bsy, dn, ov;
    logic [4:0] cnt;
  } out_t;
  typedef struct {
    logic       st;
    logic [3:0] sa;
    logic       v;
    logic [7:0] d;
    logic       l;
    out_t       e;
  } vec_t;
  logic       clk = 0, rst = 1, start = 0, s_valid = 0, s_last = 0;
  logic [3:0] start_addr = 0;
  logic [7:0] s_data = 0;
  logic       s_ready, ram_lohi, ram_w_en, busy, done, ovf;
  logic [3:0] ram_addr, ram_wdata;
  logic [4:0] count;
  int         n_run = 0, n_fail = 0;
  vec_t       vt[$];
  dffram_burst_writer dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_lohi(ram_lohi), .ram_w_en(ram_w_en),
    .busy(busy), .done(done), .ovf(ovf), .count(count)
  );
  always #5 clk = ~clk;
  function automatic out_t o(input logic r, w, lh, input logic [3:0] wd, ad,
                             input logic b, dn, ov, input logic [4:0] c);
    return {r, w, lh, wd, ad, b, dn, ov, c};
  endfunction
  function automatic vec_t mkv(input logic st, input logic [3:0] sa, input logic v,
                               input logic [7:0] d, input logic l, input out_t e);
    vec_t r;
    r.st = st; r.sa = sa; r.v = v; r.d = d; r.l = l; r.e = e;
    return r;
  endfunction
  task automatic chk(input string nm, input out_t e);
    out_t a;
    a = {s_ready, ram_w_en, ram_lohi, ram_wdata, ram_addr, busy, done, ovf, count};
    n_run++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b wen=%b lohi=%b wd=%h ad=%h busy=%b done=%b ovf=%b cnt=%0d, expected rdy=%b wen=%b lohi=%b wd=%h ad=%h busy=%b done=%b ovf=%b cnt=%0d",
               nm, a.rdy, a.wen, a.lohi, a.wd, a.ad, a.bsy, a.dn, a.ov, a.cnt,
               e.rdy, e.wen, e.lohi, e.wd, e.ad, e.bsy, e.dn, e.ov, e.cnt);
    end
  endtask
  task automatic drive(input logic st, input logic [3:0] sa, input logic v,
                       input logic [7:0] d, input logic l);
    start = st; start_addr = sa; s_valid = v; s_data = d; s_last = l;
    @(posedge clk);
    #1;
  endtask
  initial begin
    // two-byte burst from address 3
    vt.push_back(mkv(1, 3, 0, 8'h00, 0, o(1, 0, 0, 4'h0, 3, 1, 0, 0, 0)));
    vt.push_back(mkv(0, 0, 1, 8'hA5, 0, o(0, 1, 1, 4'h5, 3, 1, 0, 0, 0)));
    vt.push_back(mkv(0, 0, 0, 8'h00, 0, o(0, 1, 0, 4'hA, 3, 1, 0, 0, 0)));
    vt.push_back(mkv(0, 0, 0, 8'h00, 0, o(1, 0, 0, 4'h0, 4, 1, 0, 0, 1)));
    vt.push_back(mkv(0, 0, 1, 8'h3C, 1, o(0, 1, 1, 4'hC, 4, 1, 0, 0, 1)));
    vt.push_back(mkv(0, 0, 0, 8'h00, 0, o(0, 1, 0, 4'h3, 4, 1, 0, 0, 1)));
    vt.push_back(mkv(0, 0, 0, 8'h00, 0, o(0, 0, 0, 4'h0, 4, 1, 1, 0, 2)));
    vt.push_back(mkv(0, 0, 0, 8'h00, 0, o(0, 0, 0, 4'h0, 4, 0, 0, 0, 2)));
    // overflow at the top address; third byte must not be taken
    vt.push_back(mkv(1, 14, 0, 8'h00, 0, o(1, 0, 0, 4'h0, 14, 1, 0, 0, 0)));
    vt.push_back(mkv(0, 0, 1, 8'h21, 0, o(0, 1, 1, 4'h1, 14, 1, 0, 0, 0)));
    vt.push_back(mkv(0, 0, 0, 8'h00, 0, o(0, 1, 0, 4'h2, 14, 1, 0, 0, 0)));
    vt.push_back(mkv(0, 0, 0, 8'h00, 0, o(1, 0, 0, 4'h0, 15, 1, 0, 0, 1)));
    vt.push_back(mkv(0, 0, 1, 8'h43, 0, o(0, 1, 1, 4'h3, 15, 1, 0, 0, 1)));
    vt.push_back(mkv(0, 0, 0, 8'h00, 0, o(0, 1, 0, 4'h4, 15, 1, 0, 0, 1)));
    vt.push_back(mkv(0, 0, 1, 8'h99, 0, o(0, 0, 0, 4'h0, 15, 1, 1, 1, 2)));
    vt.push_back(mkv(0, 0, 1, 8'h99, 0, o(0, 0, 0, 4'h0, 15, 0, 0, 1, 2)));
    vt.push_back(mkv(0, 0, 1, 8'h99, 0, o(0, 0, 0, 4'h0, 15, 0, 0, 1, 2)));
    // start clears ovf; five stall cycles in ACCEPT
    vt.push_back(mkv(1, 0, 0, 8'h00, 0, o(1, 0, 0, 4'h0, 0, 1, 0, 0, 0)));
    for (int i = 0; i < 5; i++)
      vt.push_back(mkv(0, 0, 0, 8'h00, 0, o(1, 0, 0, 4'h0, 0, 1, 0, 0, 0)));
    vt.push_back(mkv(0, 0, 1, 8'h7E, 1, o(0, 1, 1, 4'hE, 0, 1, 0, 0, 0)));
    vt.push_back(mkv(0, 0, 0, 8'h00, 0, o(0, 1, 0, 4'h7, 0, 1, 0, 0, 0)));
    vt.push_back(mkv(0, 0, 0, 8'h00, 0, o(0, 0, 0, 4'h0, 0, 1, 1, 0, 1)));
    vt.push_back(mkv(0, 0, 0, 8'h00, 0, o(0, 0, 0, 4'h0, 0, 0, 0, 0, 1)));
    @(posedge clk);
    #1;
    chk("reset_state", o(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 0;
    drive(0, 0, 0, 0, 0);
    chk("idle_after_reset", o(0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (vt[i]) begin
      drive(vt[i].st, vt[i].sa, vt[i].v, vt[i].d, vt[i].l);
      chk($sformatf("vec%0d", i), vt[i].e);
    end
    // start pulsed while in WR_HI is ignored
    drive(1, 5, 0, 8'h00, 0); chk("s38_accept", o(1, 0, 0, 4'h0, 5, 1, 0, 0, 0));
    drive(0, 0, 1, 8'h12, 0); chk("s38_wrlo", o(0, 1, 1, 4'h2, 5, 1, 0, 0, 0));
    drive(0, 0, 0, 8'h00, 0); chk("s38_wrhi", o(0, 1, 0, 4'h1, 5, 1, 0, 0, 0));
    drive(1, 9, 0, 8'h00, 0); chk("s38_ignored", o(1, 0, 0, 4'h0, 6, 1, 0, 0, 1));
    drive(0, 0, 1, 8'h34, 1); chk("s38_wrlo2", o(0, 1, 1, 4'h4, 6, 1, 0, 0, 1));
    drive(0, 0, 0, 8'h00, 0); chk("s38_wrhi2", o(0, 1, 0, 4'h3, 6, 1, 0, 0, 1));
    drive(0, 0, 0, 8'h00, 0); chk("s38_done", o(0, 0, 0, 4'h0, 6, 1, 1, 0, 2));
    drive(0, 0, 0, 8'h00, 0); chk("s38_idle", o(0, 0, 0, 4'h0, 6, 0, 0, 0, 2));
    // asynchronous reset in the middle of WR_LO
    drive(1, 2, 0, 8'h00, 0); chk("s39_accept", o(1, 0, 0, 4'h0, 2, 1, 0, 0, 0));
    drive(0, 0, 1, 8'hF6, 0); chk("s39_wrlo", o(0, 1, 1, 4'h6, 2, 1, 0, 0, 0));
    #2 rst = 1;
    #1 chk("s39_async_rst", o(0, 0, 0, 4'h0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 chk("s39_no_hi_write", o(0, 0, 0, 4'h0, 0, 0, 0, 0, 0));
    rst = 0;
    drive(1, 7, 0, 8'h00, 0); chk("s39_restart", o(1, 0, 0, 4'h0, 7, 1, 0, 0, 0));
    drive(0, 0, 1, 8'h5A, 1); chk("s39_wrlo2", o(0, 1, 1, 4'hA, 7, 1, 0, 0, 0));
    drive(0, 0, 0, 8'h00, 0); chk("s39_wrhi2", o(0, 1, 0, 4'h5, 7, 1, 0, 0, 0));
    drive(0, 0, 0, 8'h00, 0); chk("s39_done", o(0, 0, 0, 4'h0, 7, 1, 1, 0, 1));
    drive(0, 0, 0, 8'h00, 0); chk("s39_idle", o(0, 0, 0, 4'h0, 7, 0, 0, 0, 1));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
